// File: rtl/message_writer.sv
// message_writer: typewriter-revealed ASCII message text for a character-cell display.
// Optional MESSAGE_WRITER_BLINK_EN blinks the WIN digit once the message is fully shown.
module message_writer #(
   parameter int COL_W        = 4,
   parameter int ROW_W        = 4,
   parameter int REVEAL_DIV   = 4,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ROW_W+COL_W-1:0] char_xy,
   input  logic [1:0]             msg_sel,
   input  logic                   winner,
   input  logic                   frame_tick,
   input  logic                   restart,
   output logic [6:0]             char_code,
   output logic                   reveal_done
);
   localparam logic [7:0] DIV_LAST = 8'(REVEAL_DIV - 1);
   logic [1:0]       msg_q;
   logic [COL_W-1:0] rev_cnt, rev_nxt, rev_eff, n_len, col;
   logic [ROW_W-1:0] row;
   logic [7:0]       div_cnt, div_nxt;
   logic [87:0]      txt;
   logic [6:0]       glyph;
   logic             clr, vis, blank;
   int               idx;
   assign row = char_xy[ROW_W+COL_W-1:COL_W];
   assign col = char_xy[COL_W-1:0];
   assign clr = restart || (msg_sel != msg_q);
   // Text is left-aligned in an 11-character field; column c maps to byte 11-c.
   always_comb begin
      n_len   = msg_sel == 2'd2 ? COL_W'(6) : msg_sel == 2'd3 ? COL_W'(9) : COL_W'(11);
      txt     = msg_sel == 2'd0 ? 88'("START GAME.")
              : msg_sel == 2'd1 ? {80'("WIN PLAYER"), 1'b0, winner ? 7'h32 : 7'h31}
              : msg_sel == 2'd2 ? {48'("PAUSED"), 40'h0}
              :                   {72'("GAME OVER"), 16'h0};
      idx     = (col == '0 || col > COL_W'(11)) ? 0 : 11 - int'(col);
      glyph   = txt[8*idx +: 7];
      rev_eff = clr ? '0 : rev_cnt;
      rev_nxt = clr ? '0
              : (frame_tick && div_cnt == DIV_LAST && rev_cnt < n_len) ? rev_cnt + 1'b1 : rev_cnt;
      div_nxt = clr ? '0 : !frame_tick ? div_cnt : div_cnt == DIV_LAST ? 8'd0 : div_cnt + 8'd1;
      vis     = row == '0 && col != '0 && col <= n_len && col <= rev_eff && !blank;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_q       <= 2'd0;
         rev_cnt     <= '0;
         div_cnt     <= 8'd0;
         reveal_done <= 1'b0;
         char_code   <= 7'h00;
      end else begin
         msg_q       <= msg_sel;
         rev_cnt     <= rev_nxt;
         div_cnt     <= div_nxt;
         reveal_done <= rev_nxt == n_len;
         char_code   <= vis ? glyph : 7'h00;
      end
   end
`ifdef MESSAGE_WRITER_BLINK_EN
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
   logic [7:0] blink_cnt;
   logic       blink_on;
   assign blank = msg_sel == 2'd1 && col == COL_W'(11) && !blink_on;
   // Blink phase only runs while the message is complete; any restart rearms it visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= 8'd0;
         blink_on  <= 1'b1;
      end else if (clr || !reveal_done) begin
         blink_cnt <= 8'd0;
         blink_on  <= 1'b1;
      end else if (frame_tick) begin
         blink_cnt <= blink_cnt == BLINK_LAST ? 8'd0 : blink_cnt + 8'd1;
         blink_on  <= blink_cnt == BLINK_LAST ? !blink_on : blink_on;
      end
   end
`else
   assign blank = 1'b0;
`endif
endmodule
